// File: rtl/muldiv_iter_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;

  // Core side: issues operations and consumes results
  modport master (
    output flush, in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, out
  );

  // Unit side: accepts operations and produces results
  modport slave (
    input  flush, in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit with ready/valid handshake and flush.
// Operands are reduced to magnitudes at accept, one shift-add or restoring-divide step
// runs per clock, and the result sign is applied on the final step.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_iter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned DW    = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  hi_q, lo_q, opnd_q, out_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             out_valid_q, in_ready_q;

  logic             out_valid_nxt, in_ready_nxt;
  logic             accept_c, last_c, calc_step_c, finish_c;

  // Operand decode at accept
  logic             a_signed_c, b_signed_c, a_neg_c, b_neg_c, neg_c;
  logic [XLEN-1:0]  a_mag_c, b_mag_c;
  logic             div_zero_c, div_ovf_c, special_c;
  logic [XLEN-1:0]  special_res_c;

  // Iteration and result shaping
  logic [XLEN:0]    mul_sum_c;
  logic [XLEN:0]    div_shift_c, div_diff_c;
  logic             div_ok_c;
  logic [XLEN-1:0]  hi_step_c, lo_step_c;
  logic [DW-1:0]    prod_c, prod_fix_c;
  logic [XLEN-1:0]  q_fix_c, r_fix_c, final_c;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;

  assign accept_c    = bus.in_valid && in_ready_q && !bus.flush;
  assign last_c      = (cnt_q == CNT_W'(XLEN - 1));
  assign calc_step_c = (state_q == CALC);
  assign finish_c    = calc_step_c && last_c && !bus.flush;

  // Signedness, magnitudes and result sign of the incoming operation
  always_comb begin
    a_signed_c = (bus.op == OP_MUL) || (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                 (bus.op == OP_DIV) || (bus.op == OP_REM);
    b_signed_c = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
                 (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_neg_c    = a_signed_c && bus.in1[XLEN-1];
    b_neg_c    = b_signed_c && bus.in2[XLEN-1];
    a_mag_c    = a_neg_c ? (XLEN'(0) - bus.in1) : bus.in1;
    b_mag_c    = b_neg_c ? (XLEN'(0) - bus.in2) : bus.in2;
    // Remainder takes the dividend's sign; everything else is the xor of operand signs
    neg_c      = (bus.op == OP_REM) ? a_neg_c : (a_neg_c ^ b_neg_c);
  end

  // Divide corner cases resolved without iterating
  always_comb begin
    div_zero_c    = bus.op[2] && (bus.in2 == '0);
    div_ovf_c     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.in1 == MIN_NEG) && (bus.in2 == '1);
    special_c     = div_zero_c || div_ovf_c;
    special_res_c = '1;
    if (div_zero_c) begin
      special_res_c = bus.op[1] ? bus.in1 : '1;
    end else if (div_ovf_c) begin
      special_res_c = bus.op[1] ? '0 : bus.in1;
    end
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift_c = {hi_q, lo_q[XLEN-1]};
    div_ok_c    = (div_shift_c >= {1'b0, opnd_q});
    div_diff_c  = div_shift_c - {1'b0, opnd_q};
    if (op_q[2]) begin
      hi_step_c = div_ok_c ? XLEN'(div_diff_c) : XLEN'(div_shift_c);
      lo_step_c = {lo_q[XLEN-2:0], div_ok_c};
    end else begin
      hi_step_c = mul_sum_c[XLEN:1];
      lo_step_c = {mul_sum_c[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection from the last step's values
  always_comb begin
    prod_c     = {hi_step_c, lo_step_c};
    prod_fix_c = neg_q ? (DW'(0) - prod_c) : prod_c;
    q_fix_c    = neg_q ? (XLEN'(0) - lo_step_c) : lo_step_c;
    r_fix_c    = neg_q ? (XLEN'(0) - hi_step_c) : hi_step_c;
    case (op_q)
      OP_MUL:                       final_c = prod_fix_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_c = prod_fix_c[DW-1:XLEN];
      OP_DIV, OP_DIVU:              final_c = q_fix_c;
      OP_REM, OP_REMU:              final_c = r_fix_c;
      default:                      final_c = '0;
    endcase
  end

  // Next state and next registered handshake outputs
  always_comb begin
    state_nxt     = state_q;
    out_valid_nxt = 1'b0;
    in_ready_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_nxt = special_c ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_c) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
    end
    // Valid rises one cycle after entering DONE and drops on handshake or flush
    out_valid_nxt = (state_q == DONE) && !(out_valid_q && bus.out_ready) && !bus.flush;
    in_ready_nxt  = (state_nxt == IDLE);
  end

  // State and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      out_valid_q <= out_valid_nxt;
      in_ready_q  <= in_ready_nxt;
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
    end else if (accept_c) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= bus.op[2] ? a_mag_c : b_mag_c;
      opnd_q <= bus.op[2] ? b_mag_c : a_mag_c;
      op_q   <= bus.op;
      neg_q  <= neg_c;
    end else if (calc_step_c) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      hi_q   <= hi_step_c;
      lo_q   <= lo_step_c;
    end
  end

  // Result register; holds the last result until a new one is produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (accept_c && special_c) begin
      out_q <= special_res_c;
    end else if (finish_c) begin
      out_q <= final_c;
    end
  end

endmodule
